instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/HOLD fetch FSM, next-PC selection (sequential, branch, jump).
// Optional retired-instruction counter is enabled by defining FETCH_INSTR_COUNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic        zero,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Low two bits forced clear so a misaligned RESET_PC can never reach the bus.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] instr_reg;
    logic [31:0] pc_out_reg;
    logic [31:0] pc_seq;
    logic [31:0] branch_off;
    logic        capture;
    logic        retire;

    assign capture = (state_reg == REQ)  && imem_ready;
    assign retire  = (state_reg == HOLD) && instr_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = REQ;
            REQ:     state_next = imem_ready ? HOLD : REQ;
            HOLD:    state_next = instr_ack ? REQ : HOLD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_reg == REQ);
        instr_valid = (state_reg == HOLD);
    end

    // Next PC is relative to the instruction being retired, not the fetch pointer.
    assign pc_seq     = pc_out_reg + 32'd4;
    assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    always_comb begin
        pc_next = pc_seq;
        if (jump) begin
            pc_next = {pc_seq[31:28], jump_target, 2'b00};
        end else if (branch && zero) begin
            pc_next = pc_seq + branch_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg     <= RESET_PC_ALIGNED;
            instr_reg  <= 32'h0;
            pc_out_reg <= RESET_PC_ALIGNED;
        end else begin
            if (capture) begin
                instr_reg  <= imem_rdata;
                pc_out_reg <= pc_reg;
            end
            if (retire) begin
                pc_reg <= pc_next;
            end
        end
    end

    assign imem_addr = pc_reg;
    assign instr     = instr_reg;
    assign pc_out    = pc_out_reg;

`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 32'h0;
        end else if (retire) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign instr_count = count_reg;
`else
    assign instr_count = 32'h0;
`endif

endmodule
